// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
//   Groups the byte-stream handshake and the instruction-memory programming
//   bus of the instruction-memory loader.
//
//   rx_data        [7:0]            incoming byte
//   rx_valid                        rx_data valid
//   rx_ready                        loader can accept a byte
//   mem_write_addr [ADDR_WIDTH-1:0] byte address to the programming port
//   mem_write_data [31:0]           word to write
//   mem_w_en                        single-cycle write strobe
//
//   modport master : the loader (consumes bytes, drives the memory bus)
//   modport slave  : the environment (byte source and memory)
// ----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 14
) ();

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [31:0]           mem_write_data;
  logic                  mem_w_en;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_write_addr,
    output mem_write_data,
    output mem_w_en
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_write_addr,
    input  mem_write_data,
    input  mem_w_en
  );

endinterface

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Receives a framed byte stream and writes it into instruction memory while
//   holding the CPU. Frame: 0xA5, word count N (16-bit little-endian), then
//   N little-endian 32-bit words written at byte addresses 0, 4, 8, ...
//   A count that does not fit the memory, or an idle gap of TIMEOUT_CYCLES
//   inside a frame, aborts the load and raises the sticky load_error flag.
//
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        imem_loader_if.master (byte handshake + memory write bus)
//   cpu_hold   stalls the core while a load is in progress
//   load_done  one-cycle pulse on successful completion
//   load_error sticky abort flag, cleared by the next accepted 0xA5
// ----------------------------------------------------------------------------
module imem_loader #(
  parameter int INST_MEMORY_SIZE = 16384,
  parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
  parameter int TIMEOUT_CYCLES   = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  imem_loader_if.master   bus,
  output logic            cpu_hold,
  output logic            load_done,
  output logic            load_error
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [31:0] MAX_WORDS = 32'(INST_MEMORY_SIZE / 4);
  localparam int          TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  state_t          state_q,      state_d;
  logic [15:0]     len_q,        len_d;
  logic [31:0]     data_q,       data_d;
  logic [1:0]      byte_cnt_q,   byte_cnt_d;
  logic [15:0]     word_cnt_q,   word_cnt_d;
  logic [TO_W-1:0] to_cnt_q,     to_cnt_d;
  logic            load_error_q, load_error_d;

  logic            ready_s;
  logic            waiting_s;
  logic            accept_s;
  logic            timeout_s;
  logic [15:0]     n_s;
  logic [15:0]     word_next_s;

  // Decode which states take bytes; rx_ready is forced low while rst is high.
  always_comb begin
    ready_s   = 1'b0;
    waiting_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_s   = 1'b1;
        waiting_s = 1'b0;
      end
      ST_LEN_LO, ST_LEN_HI, ST_DATA: begin
        ready_s   = 1'b1;
        waiting_s = 1'b1;
      end
      default: begin
        ready_s   = 1'b0;
        waiting_s = 1'b0;
      end
    endcase
  end

  assign bus.rx_ready = ready_s & ~rst;
  assign accept_s     = bus.rx_valid & bus.rx_ready;
  // Idle-gap detection: the last allowed idle cycle without a byte trips it.
  assign timeout_s    = waiting_s & ~accept_s & (to_cnt_q == TO_LAST);
  assign n_s          = {bus.rx_data, len_q[7:0]};
  assign word_next_s  = word_cnt_q + 16'd1;

  // Next-state, frame capture, word assembly and timeout counter.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    data_d       = data_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    load_error_d = load_error_q;

    // Counter only runs while waiting for a byte inside a frame.
    if (waiting_s && !accept_s) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s && (bus.rx_data == SYNC_BYTE)) begin
          state_d      = ST_LEN_LO;
          load_error_d = 1'b0;
          byte_cnt_d   = 2'd0;
          word_cnt_d   = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LEN_LO: begin
        if (timeout_s) begin
          state_d      = ST_ERROR;
          load_error_d = 1'b1;
        end else if (accept_s) begin
          len_d   = {8'd0, bus.rx_data};
          state_d = ST_LEN_HI;
        end else begin
          state_d = ST_LEN_LO;
        end
      end

      ST_LEN_HI: begin
        if (timeout_s) begin
          state_d      = ST_ERROR;
          load_error_d = 1'b1;
        end else if (accept_s) begin
          len_d = n_s;
          if (n_s == 16'd0) begin
            state_d = ST_DONE;
          end else if ({16'd0, n_s} > MAX_WORDS) begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN_HI;
        end
      end

      ST_DATA: begin
        if (timeout_s) begin
          state_d      = ST_ERROR;
          load_error_d = 1'b1;
        end else if (accept_s) begin
          case (byte_cnt_q)
            2'd0:    data_d[7:0]   = bus.rx_data;
            2'd1:    data_d[15:8]  = bus.rx_data;
            2'd2:    data_d[23:16] = bus.rx_data;
            default: data_d[31:24] = bus.rx_data;
          endcase
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = ST_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      // The word counter advances only after the strobe so the address is
      // stable for the whole WRITE cycle.
      ST_WRITE: begin
        word_cnt_d = word_next_s;
        if (word_next_s == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERROR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= 16'd0;
      data_q       <= 32'd0;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= 16'd0;
      to_cnt_q     <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      data_q       <= data_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      to_cnt_q     <= to_cnt_d;
      load_error_q <= load_error_d;
    end
  end

  // Outputs decode straight from registers, so they are glitch-free and
  // drop to their idle values the moment rst is asserted.
  assign bus.mem_write_addr = {word_cnt_q[ADDR_WIDTH-3:0], 2'b00};
  assign bus.mem_write_data = data_q;
  assign bus.mem_w_en       = (state_q == ST_WRITE);
  assign cpu_hold           = (state_q != ST_IDLE);
  assign load_done          = (state_q == ST_DONE);
  assign load_error         = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Expected memory writes are queued as
//   stimulus is sent and compared by a negedge monitor whenever mem_w_en is
//   seen; cycle-exact behaviour is checked inline.
// ----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int MEM = 16384;
  localparam int AW  = 14;
  localparam int TO  = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic cpu_hold;
  logic load_done;
  logic load_error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(
    .INST_MEMORY_SIZE(MEM),
    .ADDR_WIDTH      (AW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   wr_cnt   = 0;
  int   done_cnt = 0;
  logic prev_wen = 1'b0;
  wr_t  exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_w_en) begin
        wr_cnt++;
        check_eq("w_en_single", {31'd0, prev_wen}, 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check_eq("wr_addr", 32'(bus.mem_write_addr), 32'(e.addr));
          check_eq("wr_data", bus.mem_write_data, e.data);
        end
      end
      if (load_done) begin
        done_cnt++;
      end
    end
    prev_wen = bus.mem_w_en;
  end

  // Drive one byte; called at a negedge, returns at the negedge after accept.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.rx_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    if (!ok) check_eq("send_stall", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int w0;

    // ---------------- reset state ----------------
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(3);
    check_eq("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check_eq("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_eq("rst_w_en", {31'd0, bus.mem_w_en}, 32'd0);
    check_eq("rst_done", {31'd0, load_done}, 32'd0);
    check_eq("rst_error", {31'd0, load_error}, 32'd0);
    check_eq("rst_addr", 32'(bus.mem_write_addr), 32'd0);
    check_eq("rst_data", bus.mem_write_data, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", {31'd0, bus.rx_ready}, 32'd1);
    @(negedge clk);

    // ---------------- two-word load ----------------
    push_wr(14'd0, 32'h12345678);
    push_wr(14'd4, 32'hDEADBEEF);
    send_byte(8'hA5);
    check_eq("a_hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h12345678);
    check_eq("a_w_en0", {31'd0, bus.mem_w_en}, 32'd1);
    check_eq("a_ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
    send_word(32'hDEADBEEF);
    check_eq("a_w_en1", {31'd0, bus.mem_w_en}, 32'd1);
    idle(1);
    check_eq("a_done", {31'd0, load_done}, 32'd1);
    check_eq("a_hold_done", {31'd0, cpu_hold}, 32'd1);
    idle(1);
    check_eq("a_done_pulse", {31'd0, load_done}, 32'd0);
    check_eq("a_hold_release", {31'd0, cpu_hold}, 32'd0);
    check_eq("a_writes", wr_cnt, 32'd2);

    // ---------------- zero-length load ----------------
    w0 = wr_cnt;
    check_eq("b_hold_before", {31'd0, cpu_hold}, 32'd0);
    send_byte(8'hA5);
    check_eq("b_hold_sync", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("b_done", {31'd0, load_done}, 32'd1);
    check_eq("b_hold_done", {31'd0, cpu_hold}, 32'd1);
    idle(1);
    check_eq("b_hold_off", {31'd0, cpu_hold}, 32'd0);
    check_eq("b_no_write", wr_cnt - w0, 32'd0);

    // ---------------- oversized count (4097) ----------------
    w0 = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    check_eq("c_error", {31'd0, load_error}, 32'd1);
    check_eq("c_hold_err", {31'd0, cpu_hold}, 32'd1);
    idle(1);
    check_eq("c_hold_off", {31'd0, cpu_hold}, 32'd0);
    check_eq("c_error_sticky", {31'd0, load_error}, 32'd1);
    check_eq("c_no_write", wr_cnt - w0, 32'd0);
    push_wr(14'd0, 32'hCAFEF00D);
    send_byte(8'hA5);
    check_eq("c_error_cleared", {31'd0, load_error}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hCAFEF00D);
    idle(2);

    // ---------------- idle-gap timeout ----------------
    w0 = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(TO - 1);
    check_eq("d_no_early_timeout", {31'd0, load_error}, 32'd0);
    idle(1);
    check_eq("d_timeout_error", {31'd0, load_error}, 32'd1);
    idle(1);
    check_eq("d_hold_off", {31'd0, cpu_hold}, 32'd0);
    check_eq("d_error_sticky", {31'd0, load_error}, 32'd1);
    check_eq("d_no_write", wr_cnt - w0, 32'd0);

    // ---------------- toggling valid, leading junk ----------------
    send_byte(8'h00);
    idle(1);
    send_byte(8'hFF);
    idle(1);
    check_eq("e_junk_ignored", {31'd0, cpu_hold}, 32'd0);
    push_wr(14'd0, 32'h44332211);
    send_byte(8'hA5);
    idle(1);
    send_byte(8'h01);
    idle(1);
    send_byte(8'h00);
    idle(1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check_eq("e_no_early_wen", {31'd0, bus.mem_w_en}, 32'd0);
    send_byte(8'h44);
    check_eq("e_wen_t_plus_1", {31'd0, bus.mem_w_en}, 32'd1);
    idle(1);
    check_eq("e_wen_one_cycle", {31'd0, bus.mem_w_en}, 32'd0);
    check_eq("e_done", {31'd0, load_done}, 32'd1);
    idle(1);

    // ---------------- reset mid-load ----------------
    push_wr(14'd0, 32'h03020100);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h03020100);
    send_byte(8'h04);
    send_byte(8'h05);
    rst = 1'b1;
    #1;
    check_eq("f_rst_ready", {31'd0, bus.rx_ready}, 32'd0);
    check_eq("f_rst_hold", {31'd0, cpu_hold}, 32'd0);
    check_eq("f_rst_wen", {31'd0, bus.mem_w_en}, 32'd0);
    check_eq("f_rst_addr", 32'(bus.mem_write_addr), 32'd0);
    check_eq("f_rst_data", bus.mem_write_data, 32'd0);
    check_eq("f_rst_done", {31'd0, load_done}, 32'd0);
    check_eq("f_rst_error", {31'd0, load_error}, 32'd0);
    idle(2);
    rst = 1'b0;
    #1;
    check_eq("f_ready_after", {31'd0, bus.rx_ready}, 32'd1);
    @(negedge clk);
    push_wr(14'd0, 32'hA5A5_0F0F);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hA5A5_0F0F);
    check_eq("f_restart_wen", {31'd0, bus.mem_w_en}, 32'd1);
    check_eq("f_restart_addr", 32'(bus.mem_write_addr), 32'd0);
    idle(3);

    // ---------------- totals ----------------
    check_eq("queue_empty", exp_q.size(), 32'd0);
    check_eq("total_writes", wr_cnt, 32'd6);
    check_eq("total_done", done_cnt, 32'd5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter INST_MEMORY_SIZE, default 16384; instruction memory size in bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(INST_MEMORY_SIZE); byte-address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000; maximum idle gap between bytes inside a load.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port rx_data  input  8  incoming byte.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port mem_write_addr  output  ADDR_WIDTH  byte address to the instruction memory programming port.
REQ-009 SHALL have port mem_write_data  output  32  word to write.
REQ-010 SHALL have port mem_w_en  output  1  single-cycle write strobe.
REQ-011 SHALL have port cpu_hold  output  1  stalls the core while a load is in progress.
REQ-012 SHALL have port load_done  output  1  one-cycle pulse on successful completion.
REQ-013 SHALL have port load_error  output  1  sticky abort flag.

Function
REQ-014 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-015 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE and ERROR.
REQ-016 In IDLE, rx_ready SHALL be 1: an accepted byte 0xA5 SHALL go to LEN_LO, and any other accepted byte SHALL be discarded.
REQ-017 LEN_LO and LEN_HI SHALL capture a 16-bit little-endian word count N.
REQ-018 After LEN_HI, N==0 SHALL go to DONE, N>INST_MEMORY_SIZE/4 SHALL go to ERROR, and any other N SHALL go to DATA.
REQ-019 In DATA, bytes SHALL be assembled little-endian: the first byte goes to [7:0] and the fourth to [31:24].
REQ-020 On acceptance of the fourth byte, the FSM SHALL enter WRITE, asserting mem_w_en for exactly one cycle in the next cycle.
REQ-021 In WRITE, rx_ready SHALL be 0.
REQ-022 mem_write_addr SHALL equal 4*k for the k-th word (k from 0), with bits [1:0] always 0, and SHALL be stable while mem_w_en=1.
REQ-023 After WRITE, the FSM SHALL go to DONE if k+1==N, otherwise back to DATA.
REQ-024 Latency: 4th byte accepted at cycle t -> mem_w_en=1 at t+1 -> next byte acceptable at t+2.
REQ-025 cpu_hold SHALL be 1 from the cycle after 0xA5 is accepted through the DONE or ERROR cycle inclusive, and 0 otherwise.
REQ-026 DONE SHALL last one cycle with load_done=1 and then return to IDLE.
REQ-027 A timeout counter SHALL reset on every accepted byte.
REQ-028 If TIMEOUT_CYCLES consecutive cycles pass in LEN_LO, LEN_HI or DATA without an accepted byte, the FSM SHALL go to ERROR.
REQ-029 ERROR SHALL set load_error, last one cycle, and return to IDLE.
REQ-030 load_error SHALL clear when the next 0xA5 is accepted.
REQ-031 Words already written before an abort SHALL remain in memory, and no further writes SHALL occur.
REQ-032 mem_w_en SHALL never be asserted outside WRITE.
REQ-033 In LEN_LO, LEN_HI and DATA, rx_ready SHALL be 1, and 0xA5 SHALL be treated as data there.

Reset
REQ-034 rst SHALL force, immediately, state=IDLE, rx_ready=0 while rst is high, mem_w_en=0, cpu_hold=0, load_done=0, load_error=0, mem_write_addr=0, mem_write_data=0, word and byte counters=0, and timeout counter=0.
REQ-035 Reset asserted mid-load SHALL abandon the load without a write strobe, and the next load SHALL restart at address 0.
REQ-036 rx_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-037 Stream A5 02 00 78 56 34 12 EF BE AD DE -> writes 0x12345678 at addr 0 and 0xDEADBEEF at addr 4, then one load_done pulse, then cpu_hold=0.
REQ-038 Stream A5 00 00 -> no mem_w_en, load_done pulses, cpu_hold high exactly from A5+1 through the DONE cycle.
REQ-039 Stream A5 01 10 (N=4097) -> ERROR, load_error=1, no writes; then a valid load clears load_error.
REQ-040 Stream A5 01 00 11 22, then silence for TIMEOUT_CYCLES (set to 16) -> load_error=1, cpu_hold=0, no write.
REQ-041 Stream 00 FF A5 01 00 with rx_valid toggling every cycle, then 4 data bytes -> leading bytes ignored, one write at addr 0, and mem_w_en exactly 1 cycle after the 4th byte.
REQ-042 rst pulsed after the 6th data byte of an N=2 load -> all outputs reset immediately, and a following N=1 load writes at addr 0.
